// File: rtl/rs_sched_pkg.sv
// Shared definitions for the ALU reservation station: widths, opcode classes, type filter.
// Build option: RS_AGE_SELECT_EN selects oldest-ready issue instead of lowest-index.
package rs_sched_pkg;
   localparam int ROB_SIZE_WIDTH = 4;
   localparam int XLEN           = 32;
   localparam int OP_W           = 3;
   localparam int TYPE_W         = 7;

   localparam logic [TYPE_W-1:0] I_TYPE = 7'b0010011;
   localparam logic [TYPE_W-1:0] R_TYPE = 7'b0110011;
   localparam logic [TYPE_W-1:0] B_TYPE = 7'b1100011;

   function automatic logic is_alu_type(input logic [TYPE_W-1:0] t);
      return (t == I_TYPE) || (t == R_TYPE) || (t == B_TYPE);
   endfunction
endpackage

// File: rtl/rs_sched_pick.sv
// Request vector -> single grant and its index; lowest-index priority or oldest-first via age matrix.
// age[i*DEPTH+j]=1 means entry i is older than entry j (only read when AGE_MODE=1).
module rs_pick #(
   parameter int DEPTH    = 8,
   parameter bit AGE_MODE = 1'b0,
   parameter int IW       = $clog2(DEPTH)
) (
   input  logic [DEPTH-1:0]       req,
   input  logic [DEPTH*DEPTH-1:0] age,
   output logic [IW-1:0]          idx,
   output logic                   any
);
   logic [DEPTH-1:0] grant;

   generate
      if (AGE_MODE) begin : g_age
         for (genvar gi = 0; gi < DEPTH; gi++) begin : g_row
            logic [DEPTH-1:0] older;
            for (genvar gj = 0; gj < DEPTH; gj++) begin : g_col
               if (gj == gi) begin : g_diag
                  assign older[gj] = 1'b0;
               end else begin : g_off
                  assign older[gj] = age[gj*DEPTH + gi];
               end
            end
            // granted only if no other requester is older
            assign grant[gi] = req[gi] && !(|(req & older));
         end
      end else begin : g_prio
         logic unused_age;
         assign unused_age = ^age;
         assign grant = req & (~req + DEPTH'(1));
      end
   endgenerate

   always_comb begin
      idx = '0;
      for (int i = 0; i < DEPTH; i++)
         if (grant[i]) idx = idx | IW'(i);
   end

   assign any = |req;
endmodule

// File: rtl/rs_sched.sv
// ALU reservation station: holds ops until operands arrive over N_CDB buses, issues one per cycle.
// Build option: RS_AGE_SELECT_EN (oldest ready entry issues first; otherwise lowest index).
module rs_sched
   import rs_sched_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int ROB_W = ROB_SIZE_WIDTH,
   parameter int N_CDB = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    rdy,
   input  logic                    flush,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [31:0]             in_instr,
   input  logic [OP_W-1:0]         in_op,
   input  logic [TYPE_W-1:0]       in_type,
   input  logic [XLEN-1:0]         in_v1,
   input  logic [XLEN-1:0]         in_v2,
   input  logic                    in_dep1,
   input  logic                    in_dep2,
   input  logic [ROB_W-1:0]        in_q1,
   input  logic [ROB_W-1:0]        in_q2,
   input  logic [ROB_W-1:0]        in_rob_id,
   input  logic [N_CDB-1:0]        cdb_valid,
   input  logic [N_CDB*ROB_W-1:0]  cdb_rob_id,
   input  logic [N_CDB*XLEN-1:0]   cdb_value,
   output logic                    ex_valid,
   input  logic                    ex_ready,
   output logic [OP_W-1:0]         ex_op,
   output logic [TYPE_W-1:0]       ex_type,
   output logic                    ex_op_other,
   output logic [XLEN-1:0]         ex_v1,
   output logic [XLEN-1:0]         ex_v2,
   output logic [ROB_W-1:0]        ex_rob_id,
   output logic [$clog2(DEPTH):0]  count
);
   localparam int IW = $clog2(DEPTH);
   localparam int CW = IW + 1;

   logic [DEPTH-1:0]  busy_reg, dep1_reg, dep2_reg, other_reg;
   logic [OP_W-1:0]   op_reg   [DEPTH];
   logic [TYPE_W-1:0] type_reg [DEPTH];
   logic [XLEN-1:0]   v1_reg   [DEPTH];
   logic [XLEN-1:0]   v2_reg   [DEPTH];
   logic [ROB_W-1:0]  q1_reg   [DEPTH];
   logic [ROB_W-1:0]  q2_reg   [DEPTH];
   logic [ROB_W-1:0]  rob_reg  [DEPTH];
   logic [CW-1:0]     count_reg;

   // {hit, value}; descending scan so the lowest matching channel is the one kept
   function automatic logic [XLEN:0] cdb_lookup(
      input logic [ROB_W-1:0]       q,
      input logic [N_CDB-1:0]       vld,
      input logic [N_CDB*ROB_W-1:0] tags,
      input logic [N_CDB*XLEN-1:0]  vals);
      logic [XLEN:0] r;
      r = '0;
      for (int c = N_CDB - 1; c >= 0; c--)
         if (vld[c] && tags[c*ROB_W +: ROB_W] == q) r = {1'b1, vals[c*XLEN +: XLEN]};
      return r;
   endfunction

   logic [XLEN:0] w1 [DEPTH];
   logic [XLEN:0] w2 [DEPTH];
   logic [XLEN:0] b1, b2;

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wake
         assign w1[gi] = cdb_lookup(q1_reg[gi], cdb_valid, cdb_rob_id, cdb_value);
         assign w2[gi] = cdb_lookup(q2_reg[gi], cdb_valid, cdb_rob_id, cdb_value);
      end
   endgenerate

   assign b1 = cdb_lookup(in_q1, cdb_valid, cdb_rob_id, cdb_value);
   assign b2 = cdb_lookup(in_q2, cdb_valid, cdb_rob_id, cdb_value);

   logic [DEPTH-1:0]       ready_vec;
   logic [IW-1:0]          sel_idx, free_idx;
   logic                   ready_any, free_any, accept, issue;
   logic [DEPTH*DEPTH-1:0] age_flat;

   assign ready_vec = busy_reg & ~dep1_reg & ~dep2_reg;

`ifdef RS_AGE_SELECT_EN
   logic [DEPTH-1:0] old_reg [DEPTH];

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age_flat
         assign age_flat[gi*DEPTH +: DEPTH] = old_reg[gi];
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) old_reg[i] <= '0;
      end else if (rdy) begin
         if (flush) begin
            for (int i = 0; i < DEPTH; i++) old_reg[i] <= '0;
         end else if (accept) begin
            // newcomer is younger than every entry currently resident
            old_reg[free_idx] <= '0;
            for (int i = 0; i < DEPTH; i++)
               if (IW'(i) != free_idx) old_reg[i][free_idx] <= busy_reg[i];
         end
      end
   end

   rs_pick #(.DEPTH(DEPTH), .AGE_MODE(1'b1)) u_ready_pick (
      .req(ready_vec), .age(age_flat), .idx(sel_idx), .any(ready_any));
`else
   assign age_flat = '0;

   rs_pick #(.DEPTH(DEPTH), .AGE_MODE(1'b0)) u_ready_pick (
      .req(ready_vec), .age(age_flat), .idx(sel_idx), .any(ready_any));
`endif

   rs_pick #(.DEPTH(DEPTH), .AGE_MODE(1'b0)) u_free_pick (
      .req(~busy_reg), .age({(DEPTH*DEPTH){1'b0}}), .idx(free_idx), .any(free_any));

   assign in_ready = (count_reg != CW'(DEPTH));
   assign accept   = rdy && !flush && in_valid && in_ready && free_any && is_alu_type(in_type);
   assign ex_valid = rdy && ready_any;
   assign issue    = ex_valid && ex_ready;
   assign count    = count_reg;

   assign ex_op       = ex_valid ? op_reg[sel_idx]   : '0;
   assign ex_type     = ex_valid ? type_reg[sel_idx] : '0;
   assign ex_op_other = ex_valid ? other_reg[sel_idx] : 1'b0;
   assign ex_v1       = ex_valid ? v1_reg[sel_idx]   : '0;
   assign ex_v2       = ex_valid ? v2_reg[sel_idx]   : '0;
   assign ex_rob_id   = ex_valid ? rob_reg[sel_idx]  : '0;

   logic unused_instr;
   assign unused_instr = ^{in_instr[31], in_instr[29:0]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_reg  <= '0;
         dep1_reg  <= '0;
         dep2_reg  <= '0;
         other_reg <= '0;
         count_reg <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            op_reg[i]   <= '0;
            type_reg[i] <= '0;
            v1_reg[i]   <= '0;
            v2_reg[i]   <= '0;
            q1_reg[i]   <= '0;
            q2_reg[i]   <= '0;
            rob_reg[i]  <= '0;
         end
      end else if (rdy) begin
         if (flush) begin
            busy_reg  <= '0;
            count_reg <= '0;
         end else begin
            for (int i = 0; i < DEPTH; i++) begin
               if (dep1_reg[i] && w1[i][XLEN]) begin
                  v1_reg[i]   <= w1[i][XLEN-1:0];
                  dep1_reg[i] <= 1'b0;
               end
               if (dep2_reg[i] && w2[i][XLEN]) begin
                  v2_reg[i]   <= w2[i][XLEN-1:0];
                  dep2_reg[i] <= 1'b0;
               end
            end
            if (issue) busy_reg[sel_idx] <= 1'b0;
            // free slot is never the issuing one, so both writes can coexist
            if (accept) begin
               busy_reg[free_idx]  <= 1'b1;
               op_reg[free_idx]    <= in_op;
               type_reg[free_idx]  <= in_type;
               other_reg[free_idx] <= in_instr[30];
               rob_reg[free_idx]   <= in_rob_id;
               q1_reg[free_idx]    <= in_q1;
               q2_reg[free_idx]    <= in_q2;
               dep1_reg[free_idx]  <= in_dep1 && !b1[XLEN];
               dep2_reg[free_idx]  <= in_dep2 && !b2[XLEN];
               v1_reg[free_idx]    <= (in_dep1 && b1[XLEN]) ? b1[XLEN-1:0] : in_v1;
               v2_reg[free_idx]    <= (in_dep2 && b2[XLEN]) ? b2[XLEN-1:0] : in_v2;
            end
            count_reg <= count_reg + CW'(accept) - CW'(issue);
         end
      end
   end
endmodule

// File: tb/tb_rs_sched.sv
// Directed bench for rs_sched: vector table for fill/wake/issue, hand sequences for stall, flush, reset, age.
module tb_rs_sched;
   localparam logic [6:0] R_T = 7'b0110011;
   localparam logic [6:0] L_T = 7'b0000011;

   logic        clk = 1'b0;
   logic        rst, rdy, flush, in_valid, in_ready;
   logic [31:0] in_instr;
   logic [2:0]  in_op;
   logic [6:0]  in_type;
   logic [31:0] in_v1, in_v2;
   logic        in_dep1, in_dep2;
   logic [3:0]  in_q1, in_q2, in_rob_id;
   logic [1:0]  cdb_valid;
   logic [7:0]  cdb_rob_id;
   logic [63:0] cdb_value;
   logic        ex_valid, ex_ready, ex_op_other;
   logic [2:0]  ex_op;
   logic [6:0]  ex_type;
   logic [31:0] ex_v1, ex_v2;
   logic [3:0]  ex_rob_id;
   logic [3:0]  count;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   rs_sched #(.DEPTH(8), .ROB_W(4), .N_CDB(2)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_op(in_op),
      .in_type(in_type), .in_v1(in_v1), .in_v2(in_v2), .in_dep1(in_dep1), .in_dep2(in_dep2),
      .in_q1(in_q1), .in_q2(in_q2), .in_rob_id(in_rob_id),
      .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_value(cdb_value),
      .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op), .ex_type(ex_type),
      .ex_op_other(ex_op_other), .ex_v1(ex_v1), .ex_v2(ex_v2), .ex_rob_id(ex_rob_id),
      .count(count));

   typedef struct {
      logic        in_valid;
      logic [6:0]  in_type;
      logic        dep1;
      logic [3:0]  q1;
      logic [31:0] v1;
      logic [3:0]  rob;
      logic        ex_ready;
      logic [1:0]  cvld;
      logic [3:0]  tag0;
      logic [31:0] val0;
      logic [3:0]  tag1;
      logic [31:0] val1;
      logic        e_in_ready;
      logic        e_ex_valid;
      logic [3:0]  e_count;
      logic [31:0] e_v1;
      logic [3:0]  e_rob;
   } vec_t;

   vec_t vq[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic v, input logic [6:0] t, input logic d1, input logic [3:0] q1,
                         input logic [31:0] v1, input logic d2, input logic [3:0] q2,
                         input logic [31:0] v2, input logic [3:0] rob);
      in_valid = v; in_type = t; in_dep1 = d1; in_q1 = q1; in_v1 = v1;
      in_dep2 = d2; in_q2 = q2; in_v2 = v2; in_rob_id = rob;
   endtask

   task automatic set_cdb(input logic [1:0] vld, input logic [3:0] t0, input logic [31:0] v0,
                          input logic [3:0] t1, input logic [31:0] v1);
      cdb_valid = vld; cdb_rob_id = {t1, t0}; cdb_value = {v1, v0};
   endtask

   task automatic idle();
      set_in(1'b0, R_T, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 4'd0);
      set_cdb(2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
      ex_ready = 1'b0; flush = 1'b0; rdy = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; in_instr = 32'h4000_0000; in_op = 3'b101;
      idle();
      repeat (2) tick();
      rst = 1'b0;
      tick();
      chk("reset_count", 32'(count), 32'd0);
      chk("reset_in_ready", 32'(in_ready), 32'd1);
      chk("reset_ex_valid", 32'(ex_valid), 32'd0);
      chk("reset_ex_fields", {ex_type, ex_op, ex_v2[21:0]}, 32'd0);

      // ---- vector table: entries i=0..7 wait on tags 8..15, rob_id=i ----
      vq.push_back('{1'b0, R_T, 1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 2'b00, 4'd0, 32'd0, 4'd0, 32'd0,
                     1'b1, 1'b0, 4'd0, 32'd0, 4'd0});
      vq.push_back('{1'b1, L_T, 1'b0, 4'd0, 32'h5, 4'd0, 1'b0, 2'b00, 4'd0, 32'd0, 4'd0, 32'd0,
                     1'b1, 1'b0, 4'd0, 32'd0, 4'd0});
      for (int i = 0; i < 8; i++)
         vq.push_back('{1'b1, R_T, 1'b1, 4'(i + 8), 32'd0, 4'(i), 1'b0, 2'b00, 4'd0, 32'd0,
                        4'd0, 32'd0, (i < 7), 1'b0, 4'(i + 1), 32'd0, 4'd0});
      vq.push_back('{1'b1, R_T, 1'b0, 4'd0, 32'h99, 4'd9, 1'b0, 2'b00, 4'd0, 32'd0, 4'd0, 32'd0,
                     1'b0, 1'b0, 4'd8, 32'd0, 4'd0});
      vq.push_back('{1'b0, R_T, 1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 2'b10, 4'd0, 32'd0, 4'd11,
                     32'hDEADBEEF, 1'b0, 1'b1, 4'd8, 32'hDEADBEEF, 4'd3});
      vq.push_back('{1'b0, R_T, 1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 2'b11, 4'd8, 32'h11, 4'd8, 32'h22,
                     1'b1, 1'b1, 4'd7, 32'h11, 4'd0});
      vq.push_back('{1'b1, R_T, 1'b0, 4'd0, 32'h55, 4'd12, 1'b1, 2'b00, 4'd0, 32'd0, 4'd0, 32'd0,
                     1'b1, 1'b1, 4'd7, 32'h55, 4'd12});
      vq.push_back('{1'b1, R_T, 1'b1, 4'd13, 32'd0, 4'd13, 1'b1, 2'b01, 4'd13, 32'h77, 4'd0, 32'd0,
                     1'b1, 1'b1, 4'd7, 32'h77, 4'd13});
      vq.push_back('{1'b0, R_T, 1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 2'b00, 4'd0, 32'd0, 4'd0, 32'd0,
                     1'b1, 1'b1, 4'd6, 32'h77, 4'd5});

      for (int k = 0; k < vq.size(); k++) begin
         set_in(vq[k].in_valid, vq[k].in_type, vq[k].dep1, vq[k].q1, vq[k].v1,
                1'b0, 4'd0, 32'd0, vq[k].rob);
         set_cdb(vq[k].cvld, vq[k].tag0, vq[k].val0, vq[k].tag1, vq[k].val1);
         ex_ready = vq[k].ex_ready;
         tick();
         $display("vec %0d: count=%0d in_ready=%0b ex_valid=%0b ex_rob=%0d ex_v1=%h",
                  k, count, in_ready, ex_valid, ex_rob_id, ex_v1);
         chk($sformatf("v%0d_count", k), 32'(count), 32'(vq[k].e_count));
         chk($sformatf("v%0d_in_ready", k), 32'(in_ready), 32'(vq[k].e_in_ready));
         chk($sformatf("v%0d_ex_valid", k), 32'(ex_valid), 32'(vq[k].e_ex_valid));
         if (vq[k].e_ex_valid) begin
            chk($sformatf("v%0d_ex_v1", k), ex_v1, vq[k].e_v1);
            chk($sformatf("v%0d_ex_rob", k), 32'(ex_rob_id), 32'(vq[k].e_rob));
            chk($sformatf("v%0d_ex_other", k), 32'(ex_op_other), 32'd1);
         end
      end

      // ---- stall: slot5 (rob 5) held while ex_ready=0 ----
      idle();
      for (int s = 0; s < 3; s++) begin
         tick();
         $display("stall %0d: count=%0d ex_rob=%0d", s, count, ex_rob_id);
         chk("stall_rob", 32'(ex_rob_id), 32'd5);
         chk("stall_v1", ex_v1, 32'h77);
         chk("stall_count", 32'(count), 32'd6);
      end

      // ---- rdy=0 freezes: no issue, no wake of slot6 (tag 14) ----
      rdy = 1'b0; ex_ready = 1'b1;
      set_cdb(2'b01, 4'd14, 32'hEE, 4'd0, 32'd0);
      tick();
      $display("hold: count=%0d ex_valid=%0b", count, ex_valid);
      chk("hold_ex_valid", 32'(ex_valid), 32'd0);
      chk("hold_count", 32'(count), 32'd6);
      chk("hold_in_ready", 32'(in_ready), 32'd1);
      idle(); ex_ready = 1'b1;
      tick();
      $display("unhold issue: count=%0d ex_valid=%0b", count, ex_valid);
      chk("unhold_count", 32'(count), 32'd5);
      chk("unhold_no_wake", 32'(ex_valid), 32'd0);

      // ---- dispatch bypass on operand 2 ----
      idle();
      set_in(1'b1, R_T, 1'b0, 4'd0, 32'd1, 1'b1, 4'd5, 32'd0, 4'd6);
      set_cdb(2'b01, 4'd5, 32'd7, 4'd0, 32'd0);
      tick();
      $display("bypass: count=%0d ex_valid=%0b ex_v2=%h", count, ex_valid, ex_v2);
      chk("bypass_count", 32'(count), 32'd6);
      chk("bypass_ex_valid", 32'(ex_valid), 32'd1);
      chk("bypass_ex_v2", ex_v2, 32'd7);
      chk("bypass_ex_v1", ex_v1, 32'd1);

      // ---- flush beats in_valid and ex_ready ----
      idle();
      set_in(1'b1, R_T, 1'b0, 4'd0, 32'd3, 1'b0, 4'd0, 32'd0, 4'd7);
      flush = 1'b1; ex_ready = 1'b1;
      tick();
      idle();
      $display("flush: count=%0d ex_valid=%0b in_ready=%0b", count, ex_valid, in_ready);
      chk("flush_count", 32'(count), 32'd0);
      chk("flush_ex_valid", 32'(ex_valid), 32'd0);
      chk("flush_in_ready", 32'(in_ready), 32'd1);
      tick();
      chk("flush_no_alloc", 32'(count), 32'd0);

      // ---- asynchronous reset with 5 entries busy ----
      for (int i = 0; i < 5; i++) begin
         set_in(1'b1, R_T, 1'b1, 4'd9, 32'd0, 1'b0, 4'd0, 32'd0, 4'(i));
         tick();
      end
      idle();
      chk("prerst_count", 32'(count), 32'd5);
      #3 rst = 1'b1;
      #1;
      $display("async rst: count=%0d ex_valid=%0b in_ready=%0b", count, ex_valid, in_ready);
      chk("arst_count", 32'(count), 32'd0);
      chk("arst_in_ready", 32'(in_ready), 32'd1);
      tick();
      chk("arst_ex_valid", 32'(ex_valid), 32'd0);
      chk("arst_count_held", 32'(count), 32'd0);
      rst = 1'b0;
      tick();

      // ---- select order: A (slot1, older) vs C (slot0, younger) woken together ----
      set_in(1'b1, R_T, 1'b0, 4'd0, 32'h10, 1'b0, 4'd0, 32'd0, 4'd10);
      tick();
      set_in(1'b1, R_T, 1'b1, 4'd1, 32'd0, 1'b0, 4'd0, 32'd0, 4'd11);
      tick();
      idle(); ex_ready = 1'b1;
      tick();
      chk("age_x_issued", 32'(count), 32'd1);
      idle();
      set_in(1'b1, R_T, 1'b1, 4'd2, 32'd0, 1'b0, 4'd0, 32'd0, 4'd12);
      tick();
      chk("age_c_alloc", 32'(count), 32'd2);
      chk("age_none_ready", 32'(ex_valid), 32'd0);
      idle();
      set_cdb(2'b11, 4'd1, 32'hA, 4'd2, 32'hC);
      tick();
      idle();
      $display("select first: ex_rob=%0d ex_v1=%h", ex_rob_id, ex_v1);
      chk("sel1_ex_valid", 32'(ex_valid), 32'd1);
`ifdef RS_AGE_SELECT_EN
      chk("sel1_rob", 32'(ex_rob_id), 32'd11);
      chk("sel1_v1", ex_v1, 32'hA);
`else
      chk("sel1_rob", 32'(ex_rob_id), 32'd12);
      chk("sel1_v1", ex_v1, 32'hC);
`endif
      ex_ready = 1'b1;
      tick();
      $display("select second: ex_rob=%0d count=%0d", ex_rob_id, count);
      chk("sel2_count", 32'(count), 32'd1);
`ifdef RS_AGE_SELECT_EN
      chk("sel2_rob", 32'(ex_rob_id), 32'd12);
`else
      chk("sel2_rob", 32'(ex_rob_id), 32'd11);
`endif
      tick();
      chk("sel_drained", 32'(count), 32'd0);
      chk("sel_drained_valid", 32'(ex_valid), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
